// File: rtl/arc_memory_pkg.sv
// Shared encodings for the ARC memory unit: access sizes, FSM states, wait-state limits.
package arc_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int MAX_WAIT_STATES = 15;
  localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/arc_memory_byte_lane.sv
// Big-endian lane steering: byte enables, write replication, read extraction with zero-extend.
module arc_memory_byte_lane
  import arc_memory_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  // be_o[i] enables word bits [8i+7:8i]; offset 0 lives in bits 31:24.
  always_comb begin
    be_o    = 4'b0000;
    wword_o = wdata_i;
    rdata_o = 32'd0;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b1000 >> addr_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {24'd0, 8'(rword_i >> {~addr_i, 3'b000})};
      end
      SIZE_HALF: begin
        be_o    = addr_i[1] ? 4'b0011 : 4'b1100;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {16'd0, (addr_i[1] ? rword_i[15:0] : rword_i[31:16])};
      end
      SIZE_WORD: begin
        be_o    = 4'b1111;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc_memory_unit.sv
// Byte-addressed big-endian memory with programmable wait states and an error response.
// Handshake: RD/WRMain are levels sampled in IDLE; ACK (with Error on a bad request) pulses
// one cycle; the unit then waits for both request levels to drop before accepting again.
module arc_memory_unit
  import arc_memory_pkg::*;
#(
  parameter int    DATAWIDTH_BUS      = 32,
  parameter int    DATAWIDTH_MEM_ADDR = 12,
  parameter int    DATAWIDTH_SIZE     = 2,
  parameter int    WAIT_STATES        = 2,
  parameter string INIT_FILE          = ""
) (
  input  logic                      ARC_MEMORY_UNIT_CLOCK_50,
  input  logic                      ARC_MEMORY_UNIT_ResetInHigh_In,
  input  logic [DATAWIDTH_BUS-1:0]  ARC_MEMORY_UNIT_A_InBus,
  input  logic [DATAWIDTH_BUS-1:0]  ARC_MEMORY_UNIT_B_InBus,
  input  logic                      ARC_MEMORY_UNIT_RD_In,
  input  logic                      ARC_MEMORY_UNIT_WRMain_In,
  input  logic [DATAWIDTH_SIZE-1:0] ARC_MEMORY_UNIT_Size_InBus,
  output logic [DATAWIDTH_BUS-1:0]  ARC_MEMORY_UNIT_Data_OutBus,
  output logic                      ARC_MEMORY_UNIT_ACK_Out,
  output logic                      ARC_MEMORY_UNIT_Error_Out
);

  localparam int N = DATAWIDTH_MEM_ADDR;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
    $error("arc_memory_unit: WAIT_STATES must be 0..15");
  end
  if (DATAWIDTH_BUS != 32) begin : g_bad_bus
    $error("arc_memory_unit: DATAWIDTH_BUS must be 32");
  end

  logic clk, rst;
  assign clk = ARC_MEMORY_UNIT_CLOCK_50;
  assign rst = ARC_MEMORY_UNIT_ResetInHigh_In;

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]            addr_q;
  logic [31:0]             wdata_q;
  logic [1:0]              size_q;
  logic                    we_q, err_q;
  logic [31:0]             data_q;
  logic                    ack_q, erro_q;
  logic [7:0]              mem [0:(2**N)-1];

  logic                    req, req_err;
  logic [N-3:0]            word_idx;
  logic [31:0]             rword, wword, rdata;
  logic [3:0]              be;
  logic                    do_write;

  assign req = ARC_MEMORY_UNIT_RD_In | ARC_MEMORY_UNIT_WRMain_In;

  // Every reason to refuse is decided once, at capture.
  assign req_err =
      (ARC_MEMORY_UNIT_RD_In & ARC_MEMORY_UNIT_WRMain_In)
    | (ARC_MEMORY_UNIT_Size_InBus == 2'b11)
    | ((ARC_MEMORY_UNIT_Size_InBus == SIZE_HALF) & ARC_MEMORY_UNIT_A_InBus[0])
    | ((ARC_MEMORY_UNIT_Size_InBus == SIZE_WORD) & (ARC_MEMORY_UNIT_A_InBus[1:0] != 2'b00))
    | (|ARC_MEMORY_UNIT_A_InBus[DATAWIDTH_BUS-1:N]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req) begin
        if (WAIT_STATES == 0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
               else             cnt_d   = cnt_q - 1'b1;
      ST_RESP: state_d = req ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_q == ST_RESP);
      erro_q  <= (state_q == ST_RESP) && err_q;
      if (state_q == ST_IDLE && req) begin
        addr_q  <= ARC_MEMORY_UNIT_A_InBus[N-1:0];
        wdata_q <= ARC_MEMORY_UNIT_B_InBus;
        size_q  <= ARC_MEMORY_UNIT_Size_InBus;
        we_q    <= ARC_MEMORY_UNIT_WRMain_In;
        err_q   <= req_err;
      end
      if (state_q == ST_RESP && !we_q && !err_q) data_q <= rdata;
    end
  end

  assign word_idx = addr_q[N-1:2];
  assign rword = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                  mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

  arc_memory_byte_lane u_lane (
    .addr_i  (addr_q[1:0]),
    .size_i  (size_q),
    .wdata_i (wdata_q),
    .rword_i (rword),
    .be_o    (be),
    .wword_o (wword),
    .rdata_o (rdata)
  );

  assign do_write = !rst && (state_q == ST_RESP) && we_q && !err_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[3-i]) mem[{word_idx, 2'(i)}] <= wword[8*(3-i) +: 8];
      end
    end
  end

  assign ARC_MEMORY_UNIT_Data_OutBus = data_q;
  assign ARC_MEMORY_UNIT_ACK_Out     = ack_q;
  assign ARC_MEMORY_UNIT_Error_Out   = erro_q;

endmodule
